// File: rtl/game_pkg.sv
// Shared definitions for the game-flow controller: state encodings and default start-up constants.
package game_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'b0000,
        ST_COVER    = 4'b0001,
        ST_PLAY     = 4'b0010,
        ST_HIT      = 4'b0011,
        ST_BOMB     = 4'b0100,
        ST_START    = 4'b0101,
        ST_GAMEOVER = 4'b1000,
        ST_SUCCESS  = 4'b1001
    } game_state_t;

    localparam int DEF_INIT_LIFE    = 3;
    localparam int DEF_INIT_BOMB    = 3;
    localparam int DEF_INVUL_CYCLES = 100_000_000;
    localparam int DEF_RST_CYCLES   = 4;

endpackage

// File: rtl/rise_edge.sv
// Registered rising-edge detector: rise is high for the first cycle that d is seen high.
module rise_edge (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic rise
);

    logic d_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) d_q <= 1'b0;
        else       d_q <= d;
    end

    assign rise = d & ~d_q;

endmodule

// File: rtl/game_ctrl_fsm.sv
// Game-flow controller: cover -> play -> game-over/success, tracks lives and bombs.
// Bomb feature is compiled in only when GAME_BOMB_EN is defined.
//
//   state    | meaning
//   IDLE     | post-reset, moves to COVER next cycle
//   COVER    | title screen, waits for an Enter press
//   START    | game_reset pulse, lives/bombs loaded
//   PLAY     | normal gameplay
//   HIT      | invulnerable after losing a life
//   BOMB     | invulnerable after using a bomb
//   GAMEOVER | no lives left, waits for Enter
//   SUCCESS  | boss defeated, waits for Enter
module game_ctrl_fsm
    import game_pkg::*;
#(
    parameter int INIT_LIFE    = DEF_INIT_LIFE,
    parameter int INIT_BOMB    = DEF_INIT_BOMB,
    parameter int INVUL_CYCLES = DEF_INVUL_CYCLES,
    parameter int RST_CYCLES   = DEF_RST_CYCLES
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       enter,
    input  logic       bomb,
    input  logic       collision,
    input  logic       die,
    output logic [3:0] num_life,
    output logic [3:0] num_bomb,
    output logic [3:0] game_state,
    output logic       game_en,
    output logic       game_reset
);

`ifdef GAME_BOMB_EN
    localparam logic BOMB_EN = 1'b1;
`else
    localparam logic BOMB_EN = 1'b0;
`endif

    localparam logic [3:0] LIFE_LOAD = 4'(INIT_LIFE);
    localparam logic [3:0] BOMB_LOAD = BOMB_EN ? 4'(INIT_BOMB) : 4'd0;
    localparam int TMAX = (INVUL_CYCLES > RST_CYCLES) ? INVUL_CYCLES : RST_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [TW-1:0] INVUL_LOAD = TW'(INVUL_CYCLES - 1);
    localparam logic [TW-1:0] RST_LOAD   = TW'(RST_CYCLES - 1);

    game_state_t   state;
    logic [TW-1:0] timer;
    logic          enter_rise;
    logic          bomb_rise;

    rise_edge u_enter_edge (
        .clk  (clk),
        .rstn (rstn),
        .d    (enter),
        .rise (enter_rise)
    );

    rise_edge u_bomb_edge (
        .clk  (clk),
        .rstn (rstn),
        .d    (bomb),
        .rise (bomb_rise)
    );

    assign game_state = state;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= ST_IDLE;
            timer      <= '0;
            num_life   <= 4'd0;
            num_bomb   <= 4'd0;
            game_en    <= 1'b0;
            game_reset <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    game_en    <= 1'b0;
                    game_reset <= 1'b0;
                    state      <= ST_COVER;
                end

                ST_COVER: begin
                    game_en    <= 1'b0;
                    game_reset <= 1'b0;
                    if (enter_rise) begin
                        state      <= ST_START;
                        game_reset <= 1'b1;
                        num_life   <= LIFE_LOAD;
                        num_bomb   <= BOMB_LOAD;
                        timer      <= RST_LOAD;
                    end
                end

                ST_START: begin
                    if (timer == '0) begin
                        state      <= ST_PLAY;
                        game_reset <= 1'b0;
                        game_en    <= 1'b1;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end

                ST_PLAY: begin
                    if (die) begin
                        state   <= ST_SUCCESS;
                        game_en <= 1'b0;
                    end else if (collision) begin
                        if (num_life != 4'd0) num_life <= num_life - 1'b1;
                        if (num_life <= 4'd1) begin
                            state   <= ST_GAMEOVER;
                            game_en <= 1'b0;
                        end else begin
                            state <= ST_HIT;
                            timer <= INVUL_LOAD;
                        end
                    end else if (BOMB_EN && bomb_rise && num_bomb != 4'd0) begin
                        num_bomb <= num_bomb - 1'b1;
                        state    <= ST_BOMB;
                        timer    <= INVUL_LOAD;
                    end
                end

                // Invulnerable window: collisions are ignored, the boss can still be finished off.
                ST_HIT, ST_BOMB: begin
                    if (die) begin
                        state   <= ST_SUCCESS;
                        game_en <= 1'b0;
                    end else if (timer == '0) begin
                        state <= ST_PLAY;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end

                ST_GAMEOVER, ST_SUCCESS: begin
                    game_en    <= 1'b0;
                    game_reset <= 1'b0;
                    if (enter_rise) state <= ST_COVER;
                end

                default: begin
                    state      <= ST_IDLE;
                    game_en    <= 1'b0;
                    game_reset <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_ctrl_fsm.sv
// Directed bench for game_ctrl_fsm; bomb checks follow whether GAME_BOMB_EN is defined.
module tb_game_ctrl_fsm;

    logic       clk = 1'b0;
    logic       rstn;
    logic       enter, bomb, collision, die;
    logic [3:0] num_life, num_bomb, game_state;
    logic       game_en, game_reset;

    int passed = 0;
    int total  = 0;

    localparam logic [3:0] S_IDLE = 4'b0000, S_COVER = 4'b0001, S_PLAY = 4'b0010,
                           S_HIT  = 4'b0011, S_BOMB  = 4'b0100, S_START = 4'b0101,
                           S_OVER = 4'b1000, S_SUCC  = 4'b1001;

`ifdef GAME_BOMB_EN
    localparam logic [3:0] EXP_BOMB = 4'd2;
`else
    localparam logic [3:0] EXP_BOMB = 4'd0;
`endif

    game_ctrl_fsm #(
        .INIT_LIFE    (3),
        .INIT_BOMB    (2),
        .INVUL_CYCLES (10),
        .RST_CYCLES   (4)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .enter      (enter),
        .bomb       (bomb),
        .collision  (collision),
        .die        (die),
        .num_life   (num_life),
        .num_bomb   (num_bomb),
        .game_state (game_state),
        .game_en    (game_en),
        .game_reset (game_reset)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0; enter = 1'b0; bomb = 1'b0; collision = 1'b0; die = 1'b0;
        repeat (3) tick();
        total++;
        if ({game_state, num_life, num_bomb, game_en, game_reset} !== 14'd0)
            $display("FAIL reset_outputs: state=%b life=%0d bomb=%0d en=%b rst=%b, want all 0",
                     game_state, num_life, num_bomb, game_en, game_reset);
        else passed++;
        rstn = 1'b1;
        total++;
        if (game_state !== S_IDLE) $display("FAIL reset_idle: state=%b want %b", game_state, S_IDLE);
        else passed++;
        tick();
        total++;
        if (game_state !== S_COVER || game_en !== 1'b0 || game_reset !== 1'b0 || num_life !== 4'd0)
            $display("FAIL reset_cover: state=%b en=%b rst=%b life=%0d want %b/0/0/0",
                     game_state, game_en, game_reset, num_life, S_COVER);
        else passed++;
    endtask

    task automatic test_start();
        int n_start = 0, n_rst = 0;
        enter = 1'b1;
        tick();
        total++;
        if (game_state !== S_START || num_life !== 4'd3 || num_bomb !== EXP_BOMB)
            $display("FAIL start_entry: state=%b life=%0d bomb=%0d want %b/3/%0d",
                     game_state, num_life, num_bomb, S_START, EXP_BOMB);
        else passed++;
        for (int i = 0; i < 20; i++) begin
            if (game_state == S_START) n_start++;
            if (game_reset) n_rst++;
            if (i < 19) tick();
        end
        enter = 1'b0;
        total++;
        if (n_start != 4 || n_rst != 4)
            $display("FAIL start_len: start_cycles=%0d reset_cycles=%0d want 4/4", n_start, n_rst);
        else passed++;
        total++;
        if (game_state !== S_PLAY || game_en !== 1'b1 || game_reset !== 1'b0)
            $display("FAIL start_play: state=%b en=%b rst=%b want %b/1/0",
                     game_state, game_en, game_reset, S_PLAY);
        else passed++;
    endtask

    task automatic test_hit();
        int n_hit = 0;
        collision = 1'b1;
        tick();
        total++;
        if (game_state !== S_HIT || num_life !== 4'd2 || game_en !== 1'b1)
            $display("FAIL hit_first: state=%b life=%0d en=%b want %b/2/1",
                     game_state, num_life, game_en, S_HIT);
        else passed++;
        while (game_state == S_HIT && n_hit < 50) begin
            n_hit++;
            tick();
        end
        total++;
        if (n_hit != 10 || num_life !== 4'd2 || game_state !== S_PLAY)
            $display("FAIL hit_window: hit_cycles=%0d life=%0d state=%b want 10/2/%b",
                     n_hit, num_life, game_state, S_PLAY);
        else passed++;
        tick();
        collision = 1'b0;
        total++;
        if (game_state !== S_HIT || num_life !== 4'd1)
            $display("FAIL hit_second: state=%b life=%0d want %b/1", game_state, num_life, S_HIT);
        else passed++;
        n_hit = 0;
        while (game_state != S_PLAY && n_hit < 50) begin
            n_hit++;
            tick();
        end
        total++;
        if (game_state !== S_PLAY) $display("FAIL hit_return: state=%b want %b", game_state, S_PLAY);
        else passed++;
    endtask

    task automatic test_gameover();
        int n = 0;
        collision = 1'b1;
        tick();
        collision = 1'b0;
        total++;
        if (game_state !== S_OVER || num_life !== 4'd0 || game_en !== 1'b0)
            $display("FAIL over_entry: state=%b life=%0d en=%b want %b/0/0",
                     game_state, num_life, game_en, S_OVER);
        else passed++;
        collision = 1'b1;
        repeat (3) tick();
        collision = 1'b0;
        total++;
        if (game_state !== S_OVER || num_life !== 4'd0)
            $display("FAIL over_frozen: state=%b life=%0d want %b/0", game_state, num_life, S_OVER);
        else passed++;
        enter = 1'b1;
        tick();
        total++;
        if (game_state !== S_COVER) $display("FAIL over_to_cover: state=%b want %b", game_state, S_COVER);
        else passed++;
        repeat (3) tick();
        total++;
        if (game_state !== S_COVER) $display("FAIL cover_held_enter: state=%b want %b", game_state, S_COVER);
        else passed++;
        enter = 1'b0;
        tick();
        enter = 1'b1;
        tick();
        enter = 1'b0;
        total++;
        if (game_state !== S_START || num_life !== 4'd3 || game_reset !== 1'b1)
            $display("FAIL reload: state=%b life=%0d rst=%b want %b/3/1",
                     game_state, num_life, game_reset, S_START);
        else passed++;
        while (game_state != S_PLAY && n < 20) begin
            n++;
            tick();
        end
        total++;
        if (game_state !== S_PLAY) $display("FAIL reload_play: state=%b want %b", game_state, S_PLAY);
        else passed++;
    endtask

`ifdef GAME_BOMB_EN
    task automatic test_bomb();
        int n;
        for (int k = 0; k < 3; k++) begin
            bomb = 1'b1;
            tick();
            bomb = 1'b0;
            if (k < 2) begin
                total++;
                if (game_state !== S_BOMB || num_bomb !== 4'(1 - k))
                    $display("FAIL bomb_use%0d: state=%b bomb=%0d want %b/%0d",
                             k, game_state, num_bomb, S_BOMB, 1 - k);
                else passed++;
                n = 0;
                while (game_state == S_BOMB && n < 50) begin
                    collision = (n < 3);
                    n++;
                    tick();
                end
                collision = 1'b0;
                total++;
                if (n != 10 || num_life !== 4'd3 || game_state !== S_PLAY)
                    $display("FAIL bomb_window%0d: cycles=%0d life=%0d state=%b want 10/3/%b",
                             k, n, num_life, game_state, S_PLAY);
                else passed++;
                tick();
            end else begin
                total++;
                if (game_state !== S_PLAY || num_bomb !== 4'd0)
                    $display("FAIL bomb_empty: state=%b bomb=%0d want %b/0", game_state, num_bomb, S_PLAY);
                else passed++;
            end
        end
    endtask
`else
    task automatic test_bomb();
        bomb = 1'b1;
        tick();
        bomb = 1'b0;
        tick();
        total++;
        if (game_state !== S_PLAY || num_bomb !== 4'd0)
            $display("FAIL bomb_disabled: state=%b bomb=%0d want %b/0", game_state, num_bomb, S_PLAY);
        else passed++;
    endtask
`endif

    task automatic test_success();
        die = 1'b1;
        collision = 1'b1;
        tick();
        die = 1'b0;
        collision = 1'b0;
        total++;
        if (game_state !== S_SUCC || num_life !== 4'd3 || game_en !== 1'b0)
            $display("FAIL success: state=%b life=%0d en=%b want %b/3/0",
                     game_state, num_life, game_en, S_SUCC);
        else passed++;
        tick();
        enter = 1'b1;
        tick();
        enter = 1'b0;
        total++;
        if (game_state !== S_COVER) $display("FAIL success_to_cover: state=%b want %b", game_state, S_COVER);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_start();
        test_hit();
        test_gameover();
        test_bomb();
        test_success();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
